// File: rtl/wbu_skid_if.sv
// wbu_skid_if: MEM-to-writeback handshake bundle.
// Carries three groups of signals:
// - in_*: the MEM-side instruction fields and the valid/ready pair.
// - out_*: the commit-port fields and the valid/ready pair.
// - fwd_* and retire_count: the bypass tap and the retire counter.
// The slave modport is the writeback stage. The master modport is the MEM/commit environment.
interface wbu_skid_if #(
    parameter int XLEN      = 32,
    parameter int CSR_WEN_W = 4,
    parameter int CNT_W     = 64
);
    localparam int AW = $clog2(XLEN / 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [XLEN-1:0]      in_ex_result;
    logic [XLEN-1:0]      in_rd_value;
    logic [XLEN-1:0]      in_mem_rdata;
    logic [AW-1:0]        in_mem_addr_lo;
    logic [2:0]           in_mem_funct3;
    logic [4:0]           in_rd;
    logic                 in_r_wen;
    logic                 in_mem_ren;
    logic                 in_jump_flag;
    logic [CSR_WEN_W-1:0] in_csr_wen;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_r_wen;
    logic [4:0]           out_rd;
    logic [XLEN-1:0]      out_rd_value;
    logic [CSR_WEN_W-1:0] out_csr_wen;
    logic [XLEN-1:0]      out_csrd;
    logic [XLEN-1:0]      out_pc;
    logic                 fwd_valid;
    logic [4:0]           fwd_rd;
    logic [XLEN-1:0]      fwd_value;
    logic [CNT_W-1:0]     retire_count;

    modport slave (
        input  in_valid, in_pc, in_ex_result, in_rd_value, in_mem_rdata, in_mem_addr_lo,
               in_mem_funct3, in_rd, in_r_wen, in_mem_ren, in_jump_flag, in_csr_wen, out_ready,
        output in_ready, out_valid, out_r_wen, out_rd, out_rd_value, out_csr_wen, out_csrd,
               out_pc, fwd_valid, fwd_rd, fwd_value, retire_count
    );

    modport master (
        output in_valid, in_pc, in_ex_result, in_rd_value, in_mem_rdata, in_mem_addr_lo,
               in_mem_funct3, in_rd, in_r_wen, in_mem_ren, in_jump_flag, in_csr_wen, out_ready,
        input  in_ready, out_valid, out_r_wen, out_rd, out_rd_value, out_csr_wen, out_csrd,
               out_pc, fwd_valid, fwd_rd, fwd_value, retire_count
    );
endinterface

// File: rtl/wbu_skid.sv
// wbu_skid: buffered writeback stage with value select, load extension, bypass tap and retire counter.
// Ports:
// - clk_i: rising-edge clock.
// - rst_ni: asynchronous active-low reset.
// - bus: wbu_skid_if.slave.
//   - in_*: MEM handshake and instruction fields.
//   - out_*: commit handshake and head-entry fields.
//   - fwd_*: bypass tap.
//   - retire_count: retire counter.
module wbu_skid #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter int CSR_WEN_W = 4,
    parameter int CNT_W     = 64
) (
    input logic       clk_i,
    input logic       rst_ni,
    wbu_skid_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0]     ret_q, ret_d;
    logic                 rdy_q;
    logic [XLEN-1:0]      pc_q   [DEPTH];
    logic [XLEN-1:0]      val_q  [DEPTH];
    logic [XLEN-1:0]      csrd_q [DEPTH];
    logic [4:0]           rd_q   [DEPTH];
    logic                 rw_q   [DEPTH];
    logic [CSR_WEN_W-1:0] cw_q   [DEPTH];
    logic                 push, pop;
    logic [XLEN-1:0]      sh, ld, val;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // rdy_q keeps in_ready low through reset while in_ready stays a pure function of flops
    assign bus.in_ready  = rdy_q & (cnt_q < CW'(DEPTH));
    assign bus.out_valid = cnt_q != '0;
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign sh   = bus.in_mem_rdata >> {bus.in_mem_addr_lo, 3'b000};

    // 32-bit variants collapse to the identity when XLEN=32, covering the LD/LWU fallback
    always_comb begin
        case (bus.in_mem_funct3)
            3'b000:  ld = XLEN'($signed(sh[7:0]));
            3'b001:  ld = XLEN'($signed(sh[15:0]));
            3'b010:  ld = XLEN'($signed(sh[31:0]));
            3'b100:  ld = XLEN'(sh[7:0]);
            3'b101:  ld = XLEN'(sh[15:0]);
            3'b110:  ld = XLEN'(sh[31:0]);
            default: ld = sh;
        endcase
    end

    always_comb begin
        val   = (bus.in_jump_flag | (|bus.in_csr_wen)) ? bus.in_rd_value :
                bus.in_mem_ren ? ld : bus.in_ex_result;
        wp_d  = push ? nxt(wp_q) : wp_q;
        rp_d  = pop ? nxt(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        ret_d = ret_q + CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            ret_q <= '0;
            rdy_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                val_q[i]  <= '0;
                csrd_q[i] <= '0;
                rd_q[i]   <= '0;
                rw_q[i]   <= 1'b0;
                cw_q[i]   <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ret_q <= ret_d;
            rdy_q <= 1'b1;
            if (push) begin
                pc_q[wp_q]   <= bus.in_pc;
                val_q[wp_q]  <= val;
                csrd_q[wp_q] <= bus.in_ex_result;
                rd_q[wp_q]   <= bus.in_rd;
                rw_q[wp_q]   <= bus.in_r_wen;
                cw_q[wp_q]   <= bus.in_csr_wen;
            end
        end
    end

    assign bus.out_r_wen    = bus.out_valid & rw_q[rp_q] & (rd_q[rp_q] != 5'd0);
    assign bus.out_rd       = rd_q[rp_q];
    assign bus.out_rd_value = val_q[rp_q];
    assign bus.out_csr_wen  = cw_q[rp_q] & {CSR_WEN_W{bus.out_valid}};
    assign bus.out_csrd     = csrd_q[rp_q];
    assign bus.out_pc       = pc_q[rp_q];
    assign bus.fwd_valid    = bus.out_r_wen;
    assign bus.fwd_rd       = rd_q[rp_q];
    assign bus.fwd_value    = val_q[rp_q];
    assign bus.retire_count = ret_q;
endmodule

// File: tb/tb_wbu_skid.sv
// tb_wbu_skid: scoreboard bench for wbu_skid at XLEN=32, DEPTH=2.
module tb_wbu_skid;
    typedef struct {
        logic [31:0] pc, val, csrd;
        logic [4:0]  rd;
        logic        rw;
        logic [3:0]  cw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0, bad = 0;
    longint ret_m = 0;
    bit rnd_on = 1'b0;
    exp_t q[$];
    exp_t cur;

    wbu_skid_if #(.XLEN(32), .CSR_WEN_W(4), .CNT_W(64)) w ();
    wbu_skid #(.XLEN(32), .DEPTH(2), .CSR_WEN_W(4), .CNT_W(64)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(w));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] s;
        s = d >> (lo * 8);
        case (f3)
            3'd0: return {{24{s[7]}}, s[7:0]};
            3'd1: return {{16{s[15]}}, s[15:0]};
            3'd4: return {24'h0, s[7:0]};
            3'd5: return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("retire", w.retire_count, 64'(ret_m));
            if (w.out_valid && w.out_ready) begin
                chk("sb_has", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rd_value", w.out_rd_value, 64'(e.val));
                    chk("rd", w.out_rd, 64'(e.rd));
                    chk("r_wen", w.out_r_wen, 64'(e.rw));
                    chk("fwd_valid", w.fwd_valid, 64'(e.rw));
                    chk("fwd_value", w.fwd_value, 64'(e.val));
                    chk("csr_wen", w.out_csr_wen, 64'(e.cw));
                    chk("csrd", w.out_csrd, 64'(e.csrd));
                    chk("pc", w.out_pc, 64'(e.pc));
                    ret_m++;
                end
            end
            if (w.in_valid && w.in_ready) q.push_back(cur);
        end
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            w.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] pc, ex, rv, md, input logic [1:0] lo, input logic [2:0] f3,
                        input logic [4:0] rd, input logic rw, mr, jp, input logic [3:0] cw,
                        input logic [31:0] ev, output int waits);
        logic r;
        w.in_pc = pc; w.in_ex_result = ex; w.in_rd_value = rv; w.in_mem_rdata = md;
        w.in_mem_addr_lo = lo; w.in_mem_funct3 = f3; w.in_rd = rd; w.in_r_wen = rw;
        w.in_mem_ren = mr; w.in_jump_flag = jp; w.in_csr_wen = cw;
        cur = '{pc: pc, val: ev, csrd: ex, rd: rd, rw: rw && rd != 0, cw: cw};
        w.in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            r = w.in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waits++;
            if (waits > 50) begin
                chk("push_timeout", 64'(waits), 0);
                break;
            end
        end
        w.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wt;
        longint r0;
        logic [31:0] ex, rv, md;
        logic [1:0] lo;
        logic [2:0] f3, k;
        logic [3:0] cw;
        w.in_valid = 0; w.out_ready = 0; w.in_pc = 0; w.in_ex_result = 0; w.in_rd_value = 0;
        w.in_mem_rdata = 0; w.in_mem_addr_lo = 0; w.in_mem_funct3 = 0; w.in_rd = 0;
        w.in_r_wen = 0; w.in_mem_ren = 0; w.in_jump_flag = 0; w.in_csr_wen = 0;
        #3;
        chk("rst_in_ready", w.in_ready, 0);
        chk("rst_out_valid", w.out_valid, 0);
        chk("rst_retire", w.retire_count, 0);
        #20 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", w.in_ready, 1);
        @(posedge clk);
        #1;
        w.out_ready = 1'b1;
        send(32'h100, 32'h1234, 0, 0, 0, 0, 5, 1, 0, 0, 0, 32'h1234, wt);
        @(negedge clk);
        chk("add_latency", w.out_valid, 1);
        chk("add_value", w.out_rd_value, 32'h1234);
        drain();
        chk("add_retired", w.retire_count, 1);
        send(32'h104, 0, 0, 32'h80FF_0000, 3, 3'b000, 7, 1, 1, 0, 0, 32'hFFFF_FF80, wt);
        send(32'h108, 0, 0, 32'h80FF_0000, 3, 3'b100, 8, 1, 1, 0, 0, 32'h0000_0080, wt);
        send(32'h10C, 32'h2000, 32'h104, 0, 0, 0, 1, 1, 0, 1, 0, 32'h104, wt);
        send(32'h110, 32'hABCD, 32'h55, 0, 0, 0, 9, 1, 0, 0, 4'b0010, 32'h55, wt);
        send(32'h114, 32'h77, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h77, wt);
        drain();
        r0 = w.retire_count;
        w.out_ready = 1'b0;
        send(32'h200, 32'hA, 0, 0, 0, 0, 10, 1, 0, 0, 0, 32'hA, wt);
        send(32'h204, 32'hB, 0, 0, 0, 0, 11, 1, 0, 0, 0, 32'hB, wt);
        @(negedge clk);
        chk("full_ready", w.in_ready, 0);
        @(posedge clk);
        #1;
        w.out_ready = 1'b1;
        send(32'h208, 32'hC, 0, 0, 0, 0, 12, 1, 0, 0, 0, 32'hC, wt);
        chk("third_wait", 64'(wt), 1);
        drain();
        chk("bp_retired", 64'(w.retire_count - r0), 3);
        rnd_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ex = $urandom; rv = $urandom; md = $urandom;
            lo = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7)); k = 3'($urandom_range(0, 3));
            cw = (k == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            send($urandom, ex, rv, md, lo, f3, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 k == 2, k == 0, cw,
                 (k == 0 || k == 1) ? rv : (k == 2) ? ld_model(md, lo, f3) : ex, wt);
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        w.out_ready = 1'b1;
        drain();
        w.out_ready = 1'b0;
        send(32'h300, 32'h1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 32'h1, wt);
        send(32'h304, 32'h2, 0, 0, 0, 0, 4, 1, 0, 0, 0, 32'h2, wt);
        @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        ret_m = 0;
        #1;
        chk("mid_rst_valid", w.out_valid, 0);
        chk("mid_rst_retire", w.retire_count, 0);
        chk("mid_rst_ready", w.in_ready, 0);
        chk("mid_rst_value", w.out_rd_value, 0);
        chk("mid_rst_fwd", w.fwd_valid, 0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_ready", w.in_ready, 1);
        chk("rel_empty", w.out_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
